// File: rtl/decoder_display_if.sv
// Bus between a host and the BCD converter / 3-digit 7-segment scanner.
// The host drives value and load strobe; the display side returns status and pins.
interface decoder_display_if;
    logic [7:0]  valor;
    logic        carrega;
    logic        ocupado;
    logic        pronto;
    logic [11:0] bcd;
    logic [2:0]  anodo;
    logic [6:0]  seg;

    modport master (
        output valor, carrega,
        input  ocupado, pronto, bcd, anodo, seg
    );

    modport slave (
        input  valor, carrega,
        output ocupado, pronto, bcd, anodo, seg
    );
endinterface

// File: rtl/decoder_display.sv
// Binary-to-BCD converter (shift-and-add-3) driving a multiplexed
// 3-digit 7-segment display with leading-zero blanking.
module decoder_display #(
    parameter int DIV_SCAN = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    decoder_display_if.slave bus
);
    localparam int CW = (DIV_SCAN > 2) ? $clog2(DIV_SCAN) : 1;

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t      state, state_nx;
    logic [7:0]  sr;
    logic [11:0] acc, adj, bcd_q;
    logic [2:0]  iter;
    logic        ocupado_q, pronto_q;
    logic [CW-1:0] scan_cnt;
    logic [1:0]  idx;
    logic [3:0]  digit;
    logic        blank;
    logic [6:0]  seg_on;

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    // FSM next-state: one load, eight shift steps, one latch step
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.carrega) state_nx = CONV;
            CONV:    if (iter == 3'd7) state_nx = LATCH;
            LATCH:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Add 3 to every BCD digit of 5 or more before the next shift
    always_comb begin
        adj = acc;
        for (int i = 0; i < 3; i++) begin
            if (acc[i*4 +: 4] >= 4'd5)
                adj[i*4 +: 4] = acc[i*4 +: 4] + 4'd3;
        end
    end

    // Conversion datapath; bcd only changes at the latch step
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr        <= '0;
            acc       <= '0;
            iter      <= '0;
            bcd_q     <= '0;
            ocupado_q <= 1'b0;
            pronto_q  <= 1'b0;
        end else begin
            pronto_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.carrega) begin
                        sr        <= bus.valor;
                        acc       <= '0;
                        iter      <= '0;
                        ocupado_q <= 1'b1;
                    end
                end
                CONV: begin
                    acc  <= {adj[10:0], sr[7]};
                    sr   <= {sr[6:0], 1'b0};
                    iter <= iter + 3'd1;
                end
                LATCH: begin
                    bcd_q     <= acc;
                    pronto_q  <= 1'b1;
                    ocupado_q <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Free-running scan divider and digit index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scan_cnt <= '0;
            idx      <= 2'd0;
        end else if (scan_cnt == CW'(DIV_SCAN - 1)) begin
            scan_cnt <= '0;
            idx      <= (idx == 2'd2) ? 2'd0 : idx + 2'd1;
        end else begin
            scan_cnt <= scan_cnt + 1'b1;
        end
    end

    // Digit select and leading-zero blanking
    always_comb begin
        digit     = bcd_q[3:0];
        blank     = 1'b0;
        bus.anodo = 3'b110;
        case (idx)
            2'd1: begin
                digit     = bcd_q[7:4];
                blank     = (bcd_q[11:8] == 4'd0) && (bcd_q[7:4] == 4'd0);
                bus.anodo = 3'b101;
            end
            2'd2: begin
                digit     = bcd_q[11:8];
                blank     = (bcd_q[11:8] == 4'd0);
                bus.anodo = 3'b011;
            end
            default: ;
        endcase
    end

    // Active-high segment table {g..a}
    always_comb begin
        seg_on = 7'h00;
        case (digit)
            4'd0: seg_on = 7'h3F;
            4'd1: seg_on = 7'h06;
            4'd2: seg_on = 7'h5B;
            4'd3: seg_on = 7'h4F;
            4'd4: seg_on = 7'h66;
            4'd5: seg_on = 7'h6D;
            4'd6: seg_on = 7'h7D;
            4'd7: seg_on = 7'h07;
            4'd8: seg_on = 7'h7F;
            4'd9: seg_on = 7'h6F;
            default: seg_on = 7'h00;
        endcase
    end

    assign bus.seg     = blank ? 7'h7F : ~seg_on;
    assign bus.bcd     = bcd_q;
    assign bus.ocupado = ocupado_q;
    assign bus.pronto  = pronto_q;
endmodule
